// File: rtl/decode_pipe_control_unit.sv
// Pipelined instruction decoder: one instruction per cycle over valid/ready, registered control bundle,
// with load-use bubbles, post-jump squashing, execute flush, downstream stall and a sticky halt.
module decode_pipe_control_unit #(
    parameter int INSN_WIDTH  = 16,
    parameter int DATA_WIDTH  = 16,
    parameter int REG_WIDTH   = 3,
    parameter int FUNC_WIDTH  = 3,
    parameter int IMM_WIDTH   = 6,
    parameter int FLUSH_SLOTS = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [INSN_WIDTH-1:0] _instruction,
    input  logic                  _insnValid,
    output logic                  insnReady,
    input  logic                  _stall,
    input  logic                  _flush,
    input  logic                  _resume,
    output logic                  outValid,
    output logic                  halt,
    output logic                  branch,
    output logic                  jump,
    output logic                  relative,
    output logic [DATA_WIDTH-1:0] destBranchJump,
    output logic [REG_WIDTH-1:0]  regA,
    output logic [REG_WIDTH-1:0]  regB,
    output logic                  regWrite,
    output logic                  muxRI,
    output logic                  overflowWrite,
    output logic                  compareWrite,
    output logic [DATA_WIDTH-1:0] immediateValue,
    output logic [FUNC_WIDTH-1:0] funcCode,
    output logic                  memoryRead,
    output logic                  memoryWrite,
    output logic                  muxMA,
    output logic                  illegal
);

    // state   | meaning
    // RUN     | normal decode, one instruction per cycle
    // SQUASH  | consuming the shadow slots behind a registered JMP
    // HALTED  | HALT registered; waits for a resume pulse

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_SQUASH = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    typedef struct packed {
        logic                  valid;
        logic                  branch;
        logic                  jump;
        logic                  relative;
        logic [DATA_WIDTH-1:0] dest;
        logic [REG_WIDTH-1:0]  reg_a;
        logic [REG_WIDTH-1:0]  reg_b;
        logic                  reg_write;
        logic                  mux_ri;
        logic                  overflow_write;
        logic                  compare_write;
        logic [DATA_WIDTH-1:0] imm_value;
        logic [FUNC_WIDTH-1:0] func_code;
        logic                  mem_read;
        logic                  mem_write;
        logic                  mux_ma;
        logic                  illegal;
    } bundle_t;

    localparam logic [3:0] OP_ALU  = 4'd0;
    localparam logic [3:0] OP_ADDI = 4'd1;
    localparam logic [3:0] OP_CMP  = 4'd2;
    localparam logic [3:0] OP_LD   = 4'd3;
    localparam logic [3:0] OP_ST   = 4'd4;
    localparam logic [3:0] OP_BR   = 4'd5;
    localparam logic [3:0] OP_JMP  = 4'd6;
    localparam logic [3:0] OP_HALT = 4'd7;

    localparam logic [2:0] SLOTS = 3'(FLUSH_SLOTS);

    state_t        state, state_next;
    logic [2:0]    squash_cnt, squash_cnt_next;
    bundle_t       bundle, bundle_next;
    bundle_t       decoded;

    logic [3:0]            opcode;
    logic [REG_WIDTH-1:0]  field_a;
    logic [REG_WIDTH-1:0]  field_b;
    logic [IMM_WIDTH-1:0]  field_imm;
    logic [DATA_WIDTH-1:0] imm_sext;
    logic                  bubble_needed;
    logic                  accept;

    assign opcode    = _instruction[INSN_WIDTH-1 -: 4];
    assign field_a   = _instruction[INSN_WIDTH-5 -: REG_WIDTH];
    assign field_b   = _instruction[INSN_WIDTH-5-REG_WIDTH -: REG_WIDTH];
    assign field_imm = _instruction[IMM_WIDTH-1:0];
    assign imm_sext  = {{(DATA_WIDTH-IMM_WIDTH){field_imm[IMM_WIDTH-1]}}, field_imm};

    // HALT decodes to an invalid NOP: the halt flag itself comes from the state.
    always_comb begin
        decoded = '0;
        if (opcode > OP_HALT) begin
            decoded.valid   = 1'b1;
            decoded.illegal = 1'b1;
        end else if (opcode != OP_HALT) begin
            decoded.valid     = 1'b1;
            decoded.reg_a     = field_a;
            decoded.reg_b     = field_b;
            decoded.imm_value = imm_sext;
            case (opcode)
                OP_ALU: begin
                    decoded.reg_write      = 1'b1;
                    decoded.overflow_write = 1'b1;
                    decoded.func_code      = _instruction[FUNC_WIDTH-1:0];
                end
                OP_ADDI: begin
                    decoded.reg_write      = 1'b1;
                    decoded.mux_ri         = 1'b1;
                    decoded.overflow_write = 1'b1;
                end
                OP_CMP: begin
                    decoded.compare_write = 1'b1;
                    decoded.func_code     = FUNC_WIDTH'(1);
                end
                OP_LD: begin
                    decoded.mem_read  = 1'b1;
                    decoded.reg_write = 1'b1;
                    decoded.mux_ri    = 1'b1;
                    decoded.mux_ma    = 1'b1;
                end
                OP_ST: begin
                    decoded.mem_write = 1'b1;
                    decoded.mux_ri    = 1'b1;
                end
                OP_BR: begin
                    decoded.branch   = 1'b1;
                    decoded.relative = 1'b1;
                    decoded.dest     = imm_sext;
                end
                OP_JMP: begin
                    decoded.jump = 1'b1;
                    decoded.dest = DATA_WIDTH'(field_imm);
                end
                default: ;
            endcase
        end
    end

    assign bubble_needed = bundle.valid && bundle.mem_read && (opcode <= OP_ST) &&
                           ((field_a == bundle.reg_a) || (field_b == bundle.reg_a));

    // Squash slots are still consumed through the handshake, so SQUASH keeps ready high.
    assign insnReady = (state != ST_HALTED) && !_stall && !_flush && !bubble_needed;
    assign accept    = _insnValid && insnReady;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_RUN;
            squash_cnt <= '0;
            bundle     <= '0;
        end else begin
            state      <= state_next;
            squash_cnt <= squash_cnt_next;
            bundle     <= bundle_next;
        end
    end

    always_comb begin
        state_next      = state;
        squash_cnt_next = squash_cnt;
        bundle_next     = bundle;
        if (_flush && state != ST_HALTED) begin
            state_next      = ST_RUN;
            squash_cnt_next = '0;
            bundle_next     = '0;
        end else if (state == ST_HALTED) begin
            if (_resume) state_next = ST_RUN;
        end else if (!_stall) begin
            bundle_next = '0;
            if (accept) begin
                if (state == ST_SQUASH) begin
                    // A squashed JMP does not restart the count; illegal still reports.
                    bundle_next.illegal = decoded.illegal;
                    squash_cnt_next     = squash_cnt - 3'd1;
                    if (squash_cnt == 3'd1) state_next = ST_RUN;
                end else begin
                    bundle_next = decoded;
                    if (opcode == OP_HALT) begin
                        state_next = ST_HALTED;
                    end else if (opcode == OP_JMP && SLOTS != 3'd0) begin
                        state_next      = ST_SQUASH;
                        squash_cnt_next = SLOTS;
                    end
                end
            end
        end
    end

    assign halt           = (state == ST_HALTED);
    assign outValid       = bundle.valid;
    assign branch         = bundle.branch;
    assign jump           = bundle.jump;
    assign relative       = bundle.relative;
    assign destBranchJump = bundle.dest;
    assign regA           = bundle.reg_a;
    assign regB           = bundle.reg_b;
    assign regWrite       = bundle.reg_write;
    assign muxRI          = bundle.mux_ri;
    assign overflowWrite  = bundle.overflow_write;
    assign compareWrite   = bundle.compare_write;
    assign immediateValue = bundle.imm_value;
    assign funcCode       = bundle.func_code;
    assign memoryRead     = bundle.mem_read;
    assign memoryWrite    = bundle.mem_write;
    assign muxMA          = bundle.mux_ma;
    assign illegal        = bundle.illegal;

endmodule

// File: tb/tb_decode_pipe_control_unit.sv
// Bench for decode_pipe_control_unit: directed vectors, a per-cycle reference model, and literal spot checks.
module tb_decode_pipe_control_unit;

    localparam int FLUSH_SLOTS = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] _instruction;
    logic        _insnValid, _stall, _flush, _resume;
    logic        insnReady, outValid, halt, branch, jump, relative;
    logic [15:0] destBranchJump, immediateValue;
    logic [2:0]  regA, regB, funcCode;
    logic        regWrite, muxRI, overflowWrite, compareWrite;
    logic        memoryRead, memoryWrite, muxMA, illegal;

    int checks   = 0;
    int failures = 0;

    decode_pipe_control_unit dut (
        .clk(clk), .reset(reset), ._instruction(_instruction), ._insnValid(_insnValid),
        .insnReady(insnReady), ._stall(_stall), ._flush(_flush), ._resume(_resume),
        .outValid(outValid), .halt(halt), .branch(branch), .jump(jump), .relative(relative),
        .destBranchJump(destBranchJump), .regA(regA), .regB(regB), .regWrite(regWrite),
        .muxRI(muxRI), .overflowWrite(overflowWrite), .compareWrite(compareWrite),
        .immediateValue(immediateValue), .funcCode(funcCode), .memoryRead(memoryRead),
        .memoryWrite(memoryWrite), .muxMA(muxMA), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid, halt, branch, jump, relative;
        logic [15:0] dest;
        logic [2:0]  ra, rb;
        logic        rw, mri, ow, cw;
        logic [15:0] imm;
        logic [2:0]  fc;
        logic        mr, mw, mma, ill;
    } obs_t;

    // Expected bundle of one accepted, non-squashed instruction, straight from the opcode table.
    function automatic obs_t model_decode(input logic [15:0] insn);
        obs_t o;
        int   opc, f6, simm;
        o    = '0;
        opc  = int'(insn[15:12]);
        f6   = int'(insn[5:0]);
        simm = (f6 >= 32) ? f6 - 64 : f6;
        if (opc >= 8) begin
            o.valid = 1'b1;
            o.ill   = 1'b1;
        end else if (opc != 7) begin
            o.valid = 1'b1;
            o.ra    = insn[11:9];
            o.rb    = insn[8:6];
            o.imm   = 16'(simm);
            case (opc)
                0: begin o.rw = 1; o.ow = 1; o.fc = insn[2:0]; end
                1: begin o.rw = 1; o.mri = 1; o.ow = 1; end
                2: begin o.cw = 1; o.fc = 3'd1; end
                3: begin o.mr = 1; o.rw = 1; o.mri = 1; o.mma = 1; end
                4: begin o.mw = 1; o.mri = 1; end
                5: begin o.branch = 1; o.relative = 1; o.dest = 16'(simm); end
                default: begin o.jump = 1; o.dest = 16'(f6); end
            endcase
        end
        return o;
    endfunction

    // Reference model state
    obs_t m_out;
    bit   m_halted;
    int   m_squash_left;

    function automatic bit model_ready();
        bit hazard;
        int opc;
        opc    = int'(_instruction[15:12]);
        hazard = m_out.valid && m_out.mr && opc <= 4 &&
                 (_instruction[11:9] == m_out.ra || _instruction[8:6] == m_out.ra);
        return !m_halted && !_stall && !_flush && !hazard;
    endfunction

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Compare process: 1 time unit before each rising edge, then advance the model across that edge.
    always @(negedge clk) begin
        obs_t act, expv;
        bit   rdy, taken;
        #4;
        if (reset) begin
            m_out         = '0;
            m_halted      = 0;
            m_squash_left = 0;
        end
        act = '{outValid, halt, branch, jump, relative, destBranchJump, regA, regB,
                regWrite, muxRI, overflowWrite, compareWrite, immediateValue, funcCode,
                memoryRead, memoryWrite, muxMA, illegal};
        expv      = m_out;
        expv.halt = m_halted;
        rdy       = model_ready();
        check("bundle", 64'(act), 64'(expv));
        check("ready", 64'(insnReady), 64'(rdy));
        if (!reset) begin
            if (_flush && !m_halted) begin
                m_out         = '0;
                m_squash_left = 0;
            end else if (m_halted) begin
                if (_resume) m_halted = 0;
            end else if (!_stall) begin
                taken = _insnValid && rdy;
                if (!taken) begin
                    m_out = '0;
                end else if (m_squash_left > 0) begin
                    m_out     = '0;
                    m_out.ill = (_instruction[15:12] >= 4'd8);
                    m_squash_left--;
                end else begin
                    m_out = model_decode(_instruction);
                    if (_instruction[15:12] == 4'd7) m_halted = 1;
                    if (_instruction[15:12] == 4'd6) m_squash_left = FLUSH_SLOTS;
                end
            end
        end
    end

    // Drive one cycle of inputs just after the falling edge.
    task automatic cyc(input logic v, input logic [15:0] insn,
                       input logic st = 0, input logic fl = 0, input logic rs = 0);
        @(negedge clk);
        #1;
        _insnValid   = v;
        _instruction = insn;
        _stall       = st;
        _flush       = fl;
        _resume      = rs;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1; _instruction = '0; _insnValid = 0; _stall = 0; _flush = 0; _resume = 0;
        repeat (2) @(negedge clk);
        #1 reset = 0;

        // Reset mid-stream: discards a registered LD immediately.
        cyc(1, 16'h1245);
        cyc(1, 16'h3700);
        cyc(0, 16'h0000);
        check("pre_rst_memread", 64'(memoryRead), 64'd1);
        reset = 1;
        #1 check("rst_memread", 64'(memoryRead), 64'd0);
        check("rst_outvalid", 64'(outValid), 64'd0);
        @(negedge clk);
        #1 reset = 0;

        // Basic ALU decode
        cyc(1, 16'h0283);
        cyc(0, 16'h0000);
        check("alu_valid", 64'(outValid), 64'd1);
        check("alu_rega", 64'(regA), 64'd1);
        check("alu_regb", 64'(regB), 64'd2);
        check("alu_func", 64'(funcCode), 64'd3);
        check("alu_regwrite", 64'(regWrite), 64'd1);
        check("alu_ovw", 64'(overflowWrite), 64'd1);
        check("alu_muxri", 64'(muxRI), 64'd0);

        // Load-use bubble
        cyc(1, 16'h3700);
        cyc(1, 16'h02C0);
        check("bubble_ready", 64'(insnReady), 64'd0);
        cyc(1, 16'h02C0);
        check("bubble_valid", 64'(outValid), 64'd0);
        cyc(0, 16'h0000);
        check("after_bubble_valid", 64'(outValid), 64'd1);
        check("after_bubble_regb", 64'(regB), 64'd3);

        // Same LD, independent consumer: no bubble
        cyc(1, 16'h3700);
        cyc(1, 16'h0283);
        check("nobubble_ready", 64'(insnReady), 64'd1);
        cyc(0, 16'h0000);
        check("nobubble_rega", 64'(regA), 64'd1);

        // Stall wins over a pending bubble
        cyc(1, 16'h3700);
        cyc(1, 16'h02C0, 1);
        cyc(1, 16'h02C0, 1);
        check("stall_bubble_memread", 64'(memoryRead), 64'd1);
        cyc(1, 16'h02C0);
        cyc(0, 16'h0000);

        // Branch, then flush
        cyc(1, 16'h503E);
        cyc(1, 16'h0283, 0, 1);
        check("br_branch", 64'(branch), 64'd1);
        check("br_relative", 64'(relative), 64'd1);
        check("br_dest", 64'(destBranchJump), 64'hFFFE);
        check("flush_ready", 64'(insnReady), 64'd0);
        cyc(0, 16'h0000);
        check("flush_valid", 64'(outValid), 64'd0);

        // Jump shadow
        cyc(1, 16'h602A);
        cyc(1, 16'h0283);
        check("jmp_jump", 64'(jump), 64'd1);
        check("jmp_dest", 64'(destBranchJump), 64'h002A);
        cyc(1, 16'h1245);
        check("squash_valid", 64'(outValid), 64'd0);
        cyc(0, 16'h0000);
        check("addi_valid", 64'(outValid), 64'd1);
        check("addi_imm", 64'(immediateValue), 64'h0005);

        // Squashed illegal still flags; squashed JMP does not restart
        cyc(1, 16'h602A);
        cyc(1, 16'hF000);
        cyc(0, 16'h0000);
        check("sq_illegal", 64'(illegal), 64'd1);
        check("sq_ill_valid", 64'(outValid), 64'd0);
        cyc(1, 16'h6001);
        cyc(1, 16'h6002);
        cyc(1, 16'h0283);
        cyc(0, 16'h0000);

        // Flush clears the squash counter
        cyc(1, 16'h602A);
        cyc(1, 16'h0283, 0, 1);
        cyc(1, 16'h1245);
        cyc(0, 16'h0000);
        check("flush_sq_addi", 64'(outValid), 64'd1);

        // Halt, flush and stall ignored while halted, then resume
        cyc(1, 16'h7000);
        for (int i = 0; i < 10; i++) begin
            cyc(1, 16'h0283, 0, (i == 4), 0);
            check("halted_halt", 64'(halt), 64'd1);
            check("halted_ready", 64'(insnReady), 64'd0);
        end
        cyc(1, 16'h0283, 0, 0, 1);
        cyc(1, 16'h0283);
        check("resume_halt", 64'(halt), 64'd0);
        check("resume_ready", 64'(insnReady), 64'd1);
        cyc(0, 16'h0000, 0, 0, 1);
        cyc(0, 16'h0000);

        // Downstream stall holds the register
        cyc(1, 16'h4100);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 16'h4100, 1);
            check("stall_ready", 64'(insnReady), 64'd0);
            check("stall_memwrite", 64'(memoryWrite), 64'd1);
            check("stall_regb", 64'(regB), 64'd4);
        end
        cyc(0, 16'h0000);
        check("stall_hold_valid", 64'(outValid), 64'd1);

        // Illegal opcode
        cyc(1, 16'hF000);
        cyc(0, 16'h0000);
        check("ill_flag", 64'(illegal), 64'd1);
        check("ill_regwrite", 64'(regWrite), 64'd0);
        cyc(0, 16'h0000);
        check("ill_clear", 64'(illegal), 64'd0);

        // Opcode sweep through every opcode with varied fields
        for (int op = 0; op < 16; op++) begin
            if (op == 7) continue;
            cyc(1, 16'((op << 12) | ((op * 37) & 16'h0FFF)));
        end
        cyc(0, 16'h0000);
        cyc(0, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
